seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Sequential display side of the adder/subtractor datapath: captures the 4-bit sum and difference produced by the math block and presents them on a 4-digit, common-anode, multiplexed seven-segment display. The block time-multiplexes the digits with a prescaled refresh counter and converts each value to decimal. It sits between the combinational arithmetic and the board's anode and segment pins.

## Interface
- REFRESH_DIV, default 100000: clock cycles per digit slot. Legal range is 1 or more. At 100 MHz the default gives 1 kHz per digit.
- clk  input  1  system clock, rising-edge
- rst_n  input  1  synchronous, active-low reset
- load  input  1  capture strobe; sum and diff are sampled on the rising edge where load=1
- sum  input  4  A+B from the math block, unsigned 0..15 (carry already discarded)
- diff  input  4  A−B from the math block
- an  output  4  digit anodes, active-low, one-hot-low while running
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; always 1

## Operation
- Capture registers sum_q and diff_q:
  - Reset to 0.
  - Load on any edge with load=1, regardless of scan position.
  - Holding load=1 captures every cycle.
- Prescaler cnt counts 0..REFRESH_DIV−1 and wraps to 0. On the wrap cycle the digit index idx (2 bits) increments 3→0 with wrap. If REFRESH_DIV=1, idx increments every cycle.
- Digit map:
  - idx0 → an=1110, diff ones
  - idx1 → an=1101, diff tens or sign
  - idx2 → an=1011, sum ones
  - idx3 → an=0111, sum tens
- Sum is shown as unsigned decimal. The tens digit shows '1' if sum_q≥10; otherwise it is blank (leading-zero blanking). The ones digit shows sum_q mod 10.
- Diff handling depends on the build (see Configuration).
- Segment patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
- Reset state for an, seg and dp is 1111, 1111111 and 1 (all off).
- While rst_n=0: cnt=0, idx=0, capture registers 0, outputs all off.
- Reset wins over a simultaneous load.

## Timing
- an, seg and dp are registered. They reflect idx and the capture registers as they stood in the previous cycle, giving 1-cycle latency.
- First edge with rst_n=1: outputs show idx0 (an=1110, seg=1000000, i.e. '0').
- Each digit is displayed for exactly REFRESH_DIV cycles. A full scan takes 4·REFRESH_DIV cycles.
- A load takes effect on the output at the edge after capture, for whichever digit is currently active. The load does not disturb cnt or idx.
- Reset asserted mid-scan: all outputs are off from the next edge. The scan restarts at idx0 after reset release.

## Configuration
- SIGNED_DIFF_EN defined: diff_q is two's complement, −8..7.
  - idx1 shows minus when diff_q[3]=1, otherwise blank.
  - idx0 shows the magnitude: 1000 → '8', 1101 → '3'.
- SIGNED_DIFF_EN undefined: diff_q is unsigned 0..15, formatted exactly like sum (tens '1' or blank, ones mod 10).

## Structure
- Package seg_scan_pkg holds:
  - The segment pattern constants (digits 0–9, minus, blank).
  - The anode one-hot constants.
  - The glyph-code typedef: 4-bit, values 0–9, 10=minus, 11=blank.
- Sub-module seg_glyph_decoder: combinational glyph code → seg pattern, instantiated once on the active digit's glyph.
- Binary-to-decimal for 4-bit values is a compare-with-10 and subtract in the top module; no divider.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: hold rst_n=0 for 5 cycles → an=1111, seg=1111111, dp=1. First edge after release → an=1110, seg=1000000.
- Scan order: with no load, an sequence 1110→1101→1011→0111→1110, each value lasting exactly 4 cycles. dp stays 1.
- Load sum=12, diff=3 → over one scan:
  - an3 '1' (1111001), an2 '2' (0100100)
  - an1 blank (1111111), an0 '3' (0110000)
- Load diff=1101:
  - With SIGNED_DIFF_EN: an1=0111111, an0=0110000.
  - Without SIGNED_DIFF_EN: an1=1111001, an0=0110000 ('13').
- With SIGNED_DIFF_EN, load diff=1000 → an1 minus, an0=0000000 ('8'). Load diff=0111 → an1 blank, an0=1111000.
- Reset during idx2 with sum=9 loaded:
  - Outputs are off on the next edge.
  - After release, scan restarts at an=1110 showing '0'.
  - sum reads as blank/'0' on an3/an2.
  - Simultaneous load during reset is ignored.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared glyph codes, segment patterns and anode constants for the
// multiplexed seven-segment display.
package seg_scan_pkg;

    typedef logic [3:0] glyph_t;

    localparam glyph_t GLYPH_MINUS = 4'd10;
    localparam glyph_t GLYPH_BLANK = 4'd11;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef struct packed {
        logic   tens;
        glyph_t ones;
    } dec_t;

    // 4-bit binary to two decimal digits: tens is only ever 0 or 1
    function automatic dec_t to_dec(input logic [3:0] v);
        dec_t d;
        if (v >= 4'd10) begin
            d.tens = 1'b1;
            d.ones = v - 4'd10;
        end else begin
            d.tens = 1'b0;
            d.ones = v;
        end
        return d;
    endfunction

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational glyph code to active-low segment pattern.
module seg_glyph_decoder
    import seg_scan_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (glyph)
            4'd0:        seg = SEG_0;
            4'd1:        seg = SEG_1;
            4'd2:        seg = SEG_2;
            4'd3:        seg = SEG_3;
            4'd4:        seg = SEG_4;
            4'd5:        seg = SEG_5;
            4'd6:        seg = SEG_6;
            4'd7:        seg = SEG_7;
            4'd8:        seg = SEG_8;
            4'd9:        seg = SEG_9;
            GLYPH_MINUS: seg = SEG_MINUS;
            default:     seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Captures sum/diff and scans them onto a 4-digit common-anode display.
// Build option: SIGNED_DIFF_EN shows diff as sign + magnitude.
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] sum,
    input  logic [3:0] diff,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [3:0]    sum_q;
    logic [3:0]    diff_q;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    glyph_t     glyph;
    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;

    dec_t   sum_dec;
    glyph_t diff_hi;
    glyph_t diff_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            diff_q <= '0;
        end else if (load) begin
            sum_q  <= sum;
            diff_q <= diff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sum_dec = to_dec(sum_q);

`ifdef SIGNED_DIFF_EN
    logic [3:0] diff_mag;

    // Two's-complement magnitude; -8 wraps to 1000 which reads as 8
    assign diff_mag = diff_q[3] ? (4'd0 - diff_q) : diff_q;
    assign diff_hi  = diff_q[3] ? GLYPH_MINUS : GLYPH_BLANK;
    assign diff_lo  = diff_mag;
`else
    dec_t diff_dec;

    assign diff_dec = to_dec(diff_q);
    assign diff_hi  = diff_dec.tens ? glyph_t'(4'd1) : GLYPH_BLANK;
    assign diff_lo  = diff_dec.ones;
`endif

    always_comb begin
        glyph  = GLYPH_BLANK;
        an_nxt = AN_OFF;
        unique case (idx)
            2'd0: begin
                an_nxt = AN_DIG0;
                glyph  = diff_lo;
            end
            2'd1: begin
                an_nxt = AN_DIG1;
                glyph  = diff_hi;
            end
            2'd2: begin
                an_nxt = AN_DIG2;
                glyph  = sum_dec.ones;
            end
            2'd3: begin
                an_nxt = AN_DIG3;
                glyph  = sum_dec.tens ? glyph_t'(4'd1) : GLYPH_BLANK;
            end
            default: begin
                an_nxt = AN_OFF;
                glyph  = GLYPH_BLANK;
            end
        endcase
    end

    seg_glyph_decoder u_dec (
        .glyph (glyph),
        .seg   (seg_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with REFRESH_DIV=4.
// Expectations follow SIGNED_DIFF_EN when the bench is built with it.
module tb_seg_scan_display;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] sum;
    logic [3:0] diff;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp;
    int n_bad;
    int k;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    seg_scan_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .sum   (sum),
        .diff  (diff),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", tag, got, exp,
                     $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    function automatic logic [3:0] an_of(input int d);
        case (d)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    // One full scan; output at tick k shows digit (k/4)%4
    task automatic scan(input string tag, input logic [6:0] e0,
                        input logic [6:0] e1, input logic [6:0] e2,
                        input logic [6:0] e3);
        logic [6:0] e;
        int d;
        for (int i = 0; i < 16; i++) begin
            tick();
            d = (k / 4) % 4;
            case (d)
                0: e = e0;
                1: e = e1;
                2: e = e2;
                default: e = e3;
            endcase
            chk({tag, "_an"}, 16'(an), 16'(an_of(d)));
            chk({tag, "_seg"}, 16'(seg), 16'(e));
            chk({tag, "_dp"}, 16'(dp), 16'd1);
        end
    endtask

    task automatic do_load(input logic [3:0] s, input logic [3:0] df);
        sum  = s;
        diff = df;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        bit found;
        n_cmp = 0;
        n_bad = 0;
        k     = 0;
        rst_n = 1'b0;
        load  = 1'b0;
        sum   = 4'd0;
        diff  = 4'd0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 16'(an), 16'b1111);
        chk("rst_seg", 16'(seg), 16'(SB));
        chk("rst_dp", 16'(dp), 16'd1);

        rst_n = 1'b1;
        k = -1;
        tick();
        chk("rel_an", 16'(an), 16'b1110);
        chk("rel_seg", 16'(seg), 16'(S0));

        scan("idle", S0, SB, S0, SB);

        do_load(4'd12, 4'd3);
        scan("s12d3", S3, SB, S2, S1);

`ifdef SIGNED_DIFF_EN
        do_load(4'd12, 4'b1101);
        scan("dneg3", S3, SM, S2, S1);
        do_load(4'd12, 4'b1000);
        scan("dneg8", S8, SM, S2, S1);
        do_load(4'd12, 4'b0111);
        scan("dpos7", S7, SB, S2, S1);
`else
        do_load(4'd12, 4'b1101);
        scan("d13", S3, S1, S2, S1);
        do_load(4'd10, 4'd15);
        scan("s10d15", S5, S1, S0, S1);
`endif

        do_load(4'd9, 4'd0);
        scan("s9", S0, SB, S9, SB);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (an == 4'b1011) found = 1'b1;
        end
        chk("find_idx2", 16'(found), 16'd1);

        rst_n = 1'b0;
        load  = 1'b1;
        sum   = 4'd5;
        diff  = 4'd7;
        tick();
        chk("mid_rst_an", 16'(an), 16'b1111);
        chk("mid_rst_seg", 16'(seg), 16'(SB));
        chk("mid_rst_dp", 16'(dp), 16'd1);
        tick();
        chk("mid_rst_an2", 16'(an), 16'b1111);
        load  = 1'b0;
        rst_n = 1'b1;
        k = -1;
        tick();
        chk("rst2_an", 16'(an), 16'b1110);
        chk("rst2_seg", 16'(seg), 16'(S0));
        scan("post_rst", S0, SB, S0, SB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
